// File: rtl/st7735_spi_seq_if.sv
// Word handshake between a pixel/command source and the ST7735 sequencer.
//   valid : source offers data/dc/last this cycle
//   ready : sequencer can take a word this cycle
//   data  : word to shift out, MSB first
//   dc    : 0 = command, 1 = data
//   last  : release CS after this word
interface st7735_spi_seq_if #(
  parameter int WORD_BITS = 8
);
  logic                 valid;
  logic                 ready;
  logic [WORD_BITS-1:0] data;
  logic                 dc;
  logic                 last;

  modport master (output valid, data, dc, last, input ready);
  modport slave  (input valid, data, dc, last, output ready);
endinterface

// File: rtl/st7735_spi_seq.sv
// ST7735 panel sequencer: power-up reset pulse and wait, then SPI mode-0
// word transfers with CS held across words until a word marked last.
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   word      : word handshake (slave side)
//   init_done : panel reset sequence complete
//   busy      : word shifting or CS gap in progress
//   cs        : panel chip select, active-low
//   mosi      : serial data, 0 whenever cs is high
//   dc        : command/data select, held while cs is high
//   lcd_clk   : serial clock, idles low
//   reset     : panel reset, active-low
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST_LOW  | panel reset driven low for RESET_LOW_CYCLES
// RST_WAIT | panel reset released, waiting RESET_WAIT_CYCLES
// IDLE     | ready for a word; cs may still be low from a non-last word
// SHIFT    | shifting a word, CLK_DIV cycles per lcd_clk phase
// GAP      | cs high for CLK_DIV cycles after a last word
module st7735_spi_seq #(
  parameter int CLK_DIV           = 2,
  parameter int WORD_BITS         = 8,
  parameter int RESET_LOW_CYCLES  = 120,
  parameter int RESET_WAIT_CYCLES = 1440000
) (
  input  logic               clk,
  input  logic               rst_n,
  st7735_spi_seq_if.slave    word,
  output logic               init_done,
  output logic               busy,
  output logic               cs,
  output logic               mosi,
  output logic               dc,
  output logic               lcd_clk,
  output logic               reset
);

  // One shared timer covers the reset phases, the clock phases and the gap.
  localparam int RST_MAX = (RESET_LOW_CYCLES > RESET_WAIT_CYCLES) ? RESET_LOW_CYCLES
                                                                   : RESET_WAIT_CYCLES;
  localparam int TMR_MAX = (RST_MAX > CLK_DIV) ? RST_MAX : CLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BIT_W   = $clog2(WORD_BITS + 1);

  localparam logic [TMR_W-1:0] LOW_TC  = TMR_W'(RESET_LOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_TC = TMR_W'(RESET_WAIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] DIV_TC  = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [BIT_W-1:0] BIT_TC  = BIT_W'(WORD_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);

  typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, SHIFT, GAP} state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [WORD_BITS-1:0] sh_q, sh_d;
  logic                 dc_q, dc_d;
  logic                 last_q, last_d;
  logic                 cs_q, cs_d;
  logic                 sclk_q, sclk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_LOW;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dc_q    <= 1'b0;
      last_q  <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dc_q    <= dc_d;
      last_q  <= last_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dc_d    = dc_q;
    last_d  = last_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    case (state_q)
      RST_LOW: begin
        if (tmr_q == LOW_TC) begin
          state_d = RST_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      RST_WAIT: begin
        if (tmr_q == WAIT_TC) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      IDLE: begin
        if (word.valid) begin
          state_d = SHIFT;
          sh_d    = word.data;
          dc_d    = word.dc;
          last_d  = word.last;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          tmr_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        if (tmr_q == DIV_TC) begin
          tmr_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Falling edge: advance to the next bit, or finish the word.
            sclk_d = 1'b0;
            if (bit_q == BIT_TC) begin
              bit_d = '0;
              if (last_q) begin
                state_d = GAP;
                cs_d    = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              bit_d = bit_q + BIT_ONE;
              sh_d  = {sh_q[WORD_BITS-2:0], 1'b0};
            end
          end
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      GAP: begin
        if (tmr_q == DIV_TC) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end
      default: state_d = RST_LOW;
    endcase
  end

  assign word.ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT) || (state_q == GAP);
  assign init_done  = (state_q != RST_LOW) && (state_q != RST_WAIT);
  assign reset      = (state_q != RST_LOW);
  assign cs         = cs_q;
  assign lcd_clk    = sclk_q;
  assign dc         = dc_q;
  assign mosi       = ~cs_q & sh_q[WORD_BITS-1];

endmodule

// File: tb/tb_st7735_spi_seq.sv
module tb_st7735_spi_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  st7735_spi_seq_if #(.WORD_BITS(8))  ifa();
  st7735_spi_seq_if #(.WORD_BITS(16)) ifb();

  logic a_init, a_busy, a_cs, a_mosi, a_dc, a_sclk, a_rst;
  logic b_init, b_busy, b_cs, b_mosi, b_dc, b_sclk, b_rst;

  st7735_spi_seq #(.CLK_DIV(1), .WORD_BITS(8), .RESET_LOW_CYCLES(4),
                   .RESET_WAIT_CYCLES(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .word(ifa), .init_done(a_init), .busy(a_busy),
    .cs(a_cs), .mosi(a_mosi), .dc(a_dc), .lcd_clk(a_sclk), .reset(a_rst));

  st7735_spi_seq #(.CLK_DIV(3), .WORD_BITS(16), .RESET_LOW_CYCLES(4),
                   .RESET_WAIT_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .word(ifb), .init_done(b_init), .busy(b_busy),
    .cs(b_cs), .mosi(b_mosi), .dc(b_dc), .lcd_clk(b_sclk), .reset(b_rst));

  typedef struct packed {
    logic [15:0] data;
    logic        dc;
  } word_t;

  word_t exp_w0[$];
  word_t exp_w1[$];
  int    exp_run0[$];
  int    exp_run1[$];

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_bits[2];
  int          m_nb[2];
  int          m_run[2];
  logic        m_prev[2];
  logic        m_dc[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: rebuilds words from lcd_clk rising edges and measures CS-low runs.
  task automatic mon_step(input int d, input logic cs_v, input logic sclk_v,
                          input logic mosi_v, input logic dc_v, input int wb);
    string tag;
    word_t e;
    int    er;
    bit    have;
    tag = (d == 0) ? "a" : "b";
    if (cs_v) check({tag, "_cs_high_pins"}, {30'd0, sclk_v, mosi_v}, 32'd0);
    if (!rst_n) begin
      m_bits[d] = '0; m_nb[d] = 0; m_run[d] = 0; m_prev[d] = 1'b0;
      return;
    end
    if (sclk_v && !m_prev[d] && !cs_v) begin
      if (m_nb[d] == 0) m_dc[d] = dc_v;
      else check({tag, "_dc_stable"}, dc_v, m_dc[d]);
      m_bits[d] = {m_bits[d][14:0], mosi_v};
      m_nb[d]++;
      if (m_nb[d] == wb) begin
        have = (d == 0) ? (exp_w0.size() > 0) : (exp_w1.size() > 0);
        if (!have) begin
          checks++;
          failures++;
          $display("FAIL %s_word actual=0x%0h expected=none", tag, m_bits[d]);
        end else begin
          if (d == 0) e = exp_w0.pop_front();
          else        e = exp_w1.pop_front();
          check({tag, "_word_data"}, m_bits[d], e.data);
          check({tag, "_word_dc"}, m_dc[d], e.dc);
        end
        m_bits[d] = '0;
        m_nb[d]   = 0;
      end
    end
    m_prev[d] = sclk_v;
    if (!cs_v) begin
      m_run[d]++;
    end else if (m_run[d] != 0) begin
      have = (d == 0) ? (exp_run0.size() > 0) : (exp_run1.size() > 0);
      if (!have) begin
        checks++;
        failures++;
        $display("FAIL %s_cs_run actual=%0d expected=none", tag, m_run[d]);
      end else begin
        if (d == 0) er = exp_run0.pop_front();
        else        er = exp_run1.pop_front();
        check({tag, "_cs_run"}, m_run[d], er);
      end
      m_run[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, a_cs, a_sclk, a_mosi, a_dc, 8);
    mon_step(1, b_cs, b_sclk, b_mosi, b_dc, 16);
  end

  // Offer a word, wait for ready, let it be accepted on the next edge.
  task automatic send(input int d, input logic [15:0] data, input logic dcv,
                      input logic lastv, input bit keep);
    int    n;
    word_t e;
    if (d == 0) begin
      ifa.valid = 1'b1; ifa.data = data[7:0]; ifa.dc = dcv; ifa.last = lastv;
    end else begin
      ifb.valid = 1'b1; ifb.data = data; ifb.dc = dcv; ifb.last = lastv;
    end
    n = 0;
    while (!((d == 0) ? ifa.ready : ifb.ready) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check((d == 0) ? "a_send_wait_bound" : "b_send_wait_bound", n < 400, 1);
    if (n >= 400) begin
      ifa.valid = 1'b0; ifb.valid = 1'b0;
      return;
    end
    e.data = data;
    e.dc   = dcv;
    if (d == 0) exp_w0.push_back(e);
    else        exp_w1.push_back(e);
    @(posedge clk); #1;
    if (!keep) begin
      if (d == 0) ifa.valid = 1'b0;
      else        ifb.valid = 1'b0;
    end
  endtask

  task automatic wait_ready(input int d, input int exp_n, input int exp_gap);
    int n;
    int gap;
    n   = 0;
    gap = 0;
    while (!((d == 0) ? ifa.ready : ifb.ready) && n < 500) begin
      @(posedge clk); #1;
      n++;
      if ((d == 0) ? (a_busy && a_cs) : (b_busy && b_cs)) gap++;
    end
    check((d == 0) ? "a_ready_latency" : "b_ready_latency", n, exp_n);
    check((d == 0) ? "a_gap_cycles" : "b_gap_cycles", gap, exp_gap);
  endtask

  task automatic reset_seq();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("a_rst_seq_k%0d", k), {a_rst, a_init, ifa.ready},
            {k >= 4, k >= 12, k >= 12});
      check($sformatf("b_rst_seq_k%0d", k), {b_rst, b_init, ifb.ready},
            {k >= 4, k >= 12, k >= 12});
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    ifa.valid = 1'b1; ifa.data = 8'h2A; ifa.dc = 1'b0; ifa.last = 1'b1;
    ifb.valid = 1'b0; ifb.data = '0;    ifb.dc = 1'b0; ifb.last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("a_reset_pins", {a_rst, a_cs, a_sclk, a_mosi, a_dc, ifa.ready, a_busy, a_init},
          8'b0100_0000);
    check("b_reset_pins", {b_rst, b_cs, b_sclk, b_mosi, b_dc, ifb.ready, b_busy, b_init},
          8'b0100_0000);
    repeat (2) @(posedge clk);

    // Valid held through the whole reset sequence; accepted only at first IDLE.
    reset_seq();
    exp_run0.push_back(16);
    send(0, 16'h002A, 1'b0, 1'b1, 1'b0);
    wait_ready(0, 17, 1);

    // Back-to-back command + data, CS low for 16+1+16 cycles.
    exp_run0.push_back(33);
    send(0, 16'h002C, 1'b0, 1'b0, 1'b1);
    send(0, 16'h00F0, 1'b1, 1'b1, 1'b0);
    wait_ready(0, 17, 1);

    // Three-word burst: 3*16 + 2 idle cycles.
    exp_run0.push_back(50);
    send(0, 16'h0001, 1'b1, 1'b0, 1'b1);
    send(0, 16'h0080, 1'b1, 1'b0, 1'b1);
    send(0, 16'h00FF, 1'b1, 1'b1, 1'b0);
    wait_ready(0, 17, 1);

    // Valid held across a GAP: two separate CS windows.
    exp_run0.push_back(16);
    exp_run0.push_back(16);
    send(0, 16'h0011, 1'b0, 1'b1, 1'b1);
    send(0, 16'h0022, 1'b1, 1'b1, 1'b0);
    wait_ready(0, 17, 1);

    // 16-bit words, CLK_DIV=3: 96 cycles per word, 3-cycle gap.
    exp_run1.push_back(96);
    send(1, 16'hF800, 1'b1, 1'b1, 1'b0);
    wait_ready(1, 99, 3);
    exp_run1.push_back(96);
    send(1, 16'h1234, 1'b0, 1'b1, 1'b0);
    wait_ready(1, 99, 3);
    exp_run1.push_back(193);
    send(1, 16'hA5A5, 1'b1, 1'b0, 1'b1);
    send(1, 16'h0001, 1'b0, 1'b1, 1'b0);
    wait_ready(1, 99, 3);

    // Abort a word mid-shift; the word is never expected on the monitor.
    ifa.valid = 1'b1; ifa.data = 8'h2A; ifa.dc = 1'b0; ifa.last = 1'b1;
    @(posedge clk); #1;
    ifa.valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("a_abort_pins", {a_rst, a_cs, a_sclk, a_mosi, ifa.ready, a_busy, a_init},
          7'b0100_000);
    repeat (3) @(posedge clk);
    reset_seq();
    exp_run0.push_back(16);
    send(0, 16'h003C, 1'b1, 1'b1, 1'b0);
    wait_ready(0, 17, 1);

    repeat (5) @(posedge clk);
    #1;
    check("a_words_left", exp_w0.size(), 0);
    check("b_words_left", exp_w1.size(), 0);
    check("a_runs_left", exp_run0.size(), 0);
    check("b_runs_left", exp_run1.size(), 0);
    check("a_partial_bits", m_nb[0], 0);
    check("b_partial_bits", m_nb[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/st7735_spi_seq.md
ST7735_SPI_SEQ -- requirements
Module: st7735_spi_seq

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning SYSTEM_CLK cycles per LCD_CLK half-period (legal range 1..255).
REQ-002 Parameter WORD_BITS, default 8, meaning bits per transfer word (legal values 8 and 16).
REQ-003 Parameter RESET_LOW_CYCLES, default 120, meaning SYSTEM_CLK cycles RESET is held low at power-up.
REQ-004 Parameter RESET_WAIT_CYCLES, default 1440000, meaning SYSTEM_CLK cycles waited after RESET release before the first transfer.
REQ-005 SYSTEM_CLK  input  1  sole clock; all logic on rising edge.
REQ-006 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-007 IN_VALID  input  1  word on IN_DATA/IN_DC/IN_LAST is offered.
REQ-008 IN_READY  output  1  block accepts a word this cycle.
REQ-009 IN_DATA  input  WORD_BITS  word to shift, MSB first.
REQ-010 IN_DC  input  1  0 = command, 1 = data; driven on DC for the whole word.
REQ-011 IN_LAST  input  1  release CS after this word.
REQ-012 INIT_DONE  output  1  panel reset sequence complete.
REQ-013 BUSY  output  1  word shifting or CS gap in progress.
REQ-014 CS, MOSI, DC, LCD_CLK, RESET  output  1 each  panel pins; CS and RESET active-low.

Function
REQ-015 States SHALL be RST_LOW, RST_WAIT, IDLE, SHIFT, GAP.
REQ-016 RST_LOW: RESET=0 for exactly RESET_LOW_CYCLES cycles, then -> RST_WAIT with RESET=1.
REQ-017 RST_WAIT: RESET=1 for exactly RESET_WAIT_CYCLES cycles, then -> IDLE and INIT_DONE=1; INIT_DONE stays 1 until reset.
REQ-018 IN_READY SHALL be 1 only in IDLE; a word is accepted when IN_VALID and IN_READY are both 1 on a rising edge.
REQ-019 On acceptance: IN_DATA, IN_DC, IN_LAST are latched; next cycle state=SHIFT, CS=0, DC=latched IN_DC, MOSI=bit WORD_BITS-1, LCD_CLK=0.
REQ-020 SHIFT: each bit is LCD_CLK=0 for CLK_DIV cycles, then LCD_CLK=1 for CLK_DIV cycles (SPI mode 0); MOSI and DC stable through the high phase; MOSI advances to the next lower bit only when LCD_CLK falls.
REQ-021 Word duration in SHIFT SHALL be exactly 2*CLK_DIV*WORD_BITS cycles; after the final high phase LCD_CLK=0.
REQ-022 Latched IN_LAST=0: -> IDLE with CS held 0; next word may be accepted in that cycle, giving back-to-back words with no CS deassertion.
REQ-023 Latched IN_LAST=1: -> GAP; CS=1 for exactly CLK_DIV cycles (minimum 1), then -> IDLE.
REQ-024 BUSY SHALL be 1 in SHIFT and GAP, 0 otherwise.
REQ-025 IN_VALID during RST_LOW/RST_WAIT/SHIFT/GAP SHALL be ignored; input values changing during SHIFT SHALL not affect the word in flight.
REQ-026 Counters SHALL be sized ceil(log2(max value + 1)); no counter wraps while in use.
REQ-027 MOSI SHALL be 0 and DC SHALL hold its last value whenever CS=1.

Reset
REQ-028 RST_N=0 SHALL immediately force: state=RST_LOW, RESET=0, CS=1, LCD_CLK=0, MOSI=0, DC=0, IN_READY=0, BUSY=0, INIT_DONE=0, all counters 0.
REQ-029 RST_N asserted mid-word SHALL abort the word with no further LCD_CLK edges; after release the full RST_LOW/RST_WAIT sequence SHALL repeat.
REQ-030 First RST_LOW cycle counted SHALL be the first rising edge with RST_N=1.

Verification (CLK_DIV=1, WORD_BITS=8, RESET_LOW_CYCLES=4, RESET_WAIT_CYCLES=8 unless noted)
REQ-031 Release RST_N -> RESET=0 for 4 cycles, 1 thereafter; INIT_DONE and IN_READY rise 12 cycles after release.
REQ-032 Send 0x2A, IN_DC=0, IN_LAST=1 -> CS=0 for 16 cycles, 8 LCD_CLK rising edges sampling MOSI 0,0,1,0,1,0,1,0, DC=0, then CS=1 for 1 cycle, IN_READY=1 next.
REQ-033 Two words 0x2C (DC=0, LAST=0) then 0xF0 (DC=1, LAST=1) with IN_VALID held -> CS low continuously 33 cycles, DC switches 0->1 at word boundary, 16 rising edges total.
REQ-034 WORD_BITS=16, CLK_DIV=3, send 0xF800 data word -> 96 cycles in SHIFT, 16 edges, sampled bits 1111100000000000.
REQ-035 Assert RST_N low at bit 3 of a word -> CS=1, LCD_CLK=0 immediately; no further edges; reset sequence restarts after release.
REQ-036 IN_VALID held high during RST_WAIT and GAP -> no acceptance until IN_READY=1; exactly one word accepted per IN_VALID&IN_READY edge.
